// File: rtl/alu_op_issuer.sv
// ALU issue front end: decodes RISC-V ALU/address/branch ops, registers operands (S1), captures result (S2).
// Optional statistics counters are enabled by defining ALU_OP_ISSUER_STATS_EN.
module alu_op_issuer #(
   parameter int DATA_WIDTH  = 64,
   parameter int STATS_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [6:0]             in_opcode,
   input  logic [2:0]             in_funct3,
   input  logic                   in_funct7_5,
   input  logic [DATA_WIDTH-1:0]  in_rs1,
   input  logic [DATA_WIDTH-1:0]  in_rs2,
   input  logic [DATA_WIDTH-1:0]  in_imm,
   output logic [DATA_WIDTH-1:0]  alu_a,
   output logic [DATA_WIDTH-1:0]  alu_b,
   output logic [3:0]             alu_ctrl,
   input  logic [DATA_WIDTH-1:0]  alu_result,
   input  logic                   alu_zero,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_result,
   output logic                   out_zero,
`ifdef ALU_OP_ISSUER_STATS_EN
   output logic [STATS_WIDTH-1:0] stat_issued,
   output logic [STATS_WIDTH-1:0] stat_illegal,
`endif
   output logic                   out_illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] CTRL_ADD = 4'b0000;
   localparam logic [3:0] CTRL_SUB = 4'b0001;
   localparam logic [3:0] CTRL_AND = 4'b0010;
   localparam logic [3:0] CTRL_OR  = 4'b0011;
   localparam logic [3:0] CTRL_XOR = 4'b0100;
   localparam logic [3:0] CTRL_SLL = 4'b0101;
   localparam logic [3:0] CTRL_SRL = 4'b0110;

   typedef struct packed {
      logic       illegal;
      logic       use_imm;
      logic [3:0] ctrl;
   } dec_t;

   function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] f3, input logic f75);
      dec_t d;
      d.illegal = 1'b0;
      d.use_imm = 1'b0;
      d.ctrl    = CTRL_ADD;
      case (opcode)
         OP_R, OP_I: begin
            d.use_imm = (opcode == OP_I);
            case (f3)
               3'b000: d.ctrl = (opcode == OP_R && f75) ? CTRL_SUB : CTRL_ADD;
               3'b111: d.ctrl = CTRL_AND;
               3'b110: d.ctrl = CTRL_OR;
               3'b100: d.ctrl = CTRL_XOR;
               // f7_5=1 on shifts selects the arithmetic variant, which this ALU lacks
               3'b001: begin d.ctrl = CTRL_SLL; d.illegal = f75; end
               3'b101: begin d.ctrl = CTRL_SRL; d.illegal = f75; end
               default: d.illegal = 1'b1;
            endcase
         end
         OP_LOAD, OP_STORE: d.use_imm = 1'b1;
         OP_BRANCH: begin
            d.ctrl    = CTRL_SUB;
            d.illegal = !(f3 == 3'b000 || f3 == 3'b001);
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   dec_t                  dec_p0;
   logic [DATA_WIDTH-1:0] a_p0;
   logic [DATA_WIDTH-1:0] b_p0;
   logic [3:0]            ctrl_p0;
   logic                  vld_p1;
   logic                  illegal_p1;
   logic                  s2_adv;
   logic                  accept;

   always_comb begin
      dec_p0  = decode(in_opcode, in_funct3, in_funct7_5);
      a_p0    = dec_p0.illegal ? '0 : in_rs1;
      b_p0    = dec_p0.illegal ? '0 : (dec_p0.use_imm ? in_imm : in_rs2);
      ctrl_p0 = dec_p0.illegal ? CTRL_ADD : dec_p0.ctrl;
   end

   assign s2_adv   = vld_p1 & (!out_valid | out_ready);
   assign in_ready = !vld_p1 | s2_adv;
   assign accept   = in_valid & in_ready;

   // p0 -> p1: issue register driving the ALU
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1     <= 1'b0;
         illegal_p1 <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= CTRL_ADD;
      end else if (accept) begin
         vld_p1     <= 1'b1;
         illegal_p1 <= dec_p0.illegal;
         alu_a      <= a_p0;
         alu_b      <= b_p0;
         alu_ctrl   <= ctrl_p0;
      end else if (s2_adv) begin
         vld_p1     <= 1'b0;
      end
   end

   // p1 -> p2: output register capturing the combinational ALU return
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_illegal <= 1'b0;
      end else if (s2_adv) begin
         out_valid   <= 1'b1;
         out_result  <= illegal_p1 ? '0 : alu_result;
         out_zero    <= illegal_p1 ? 1'b1 : alu_zero;
         out_illegal <= illegal_p1;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

`ifdef ALU_OP_ISSUER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_issued  <= '0;
         stat_illegal <= '0;
      end else if (accept) begin
         stat_issued <= stat_issued + STATS_WIDTH'(1);
         if (dec_p0.illegal) stat_illegal <= stat_illegal + STATS_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: randomized requests checked against a spec-level result model.
module tb_alu_op_issuer;
   localparam int DW = 64;
   localparam int SW = 32;
   localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011,
                          ST_OP = 7'b0100011, BR_OP = 7'b1100011;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready;
   logic [6:0]    in_opcode;
   logic [2:0]    in_funct3;
   logic          in_funct7_5;
   logic [DW-1:0] in_rs1, in_rs2, in_imm;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [3:0]    alu_ctrl;
   logic          alu_zero;
   logic          out_valid, out_ready, out_zero, out_illegal;
   logic [DW-1:0] out_result;
`ifdef ALU_OP_ISSUER_STATS_EN
   logic [SW-1:0] stat_issued, stat_illegal;
   int            m_issued, m_illegal;
`endif

   alu_op_issuer #(.DATA_WIDTH(DW), .STATS_WIDTH(SW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
`ifdef ALU_OP_ISSUER_STATS_EN
      .stat_issued(stat_issued), .stat_illegal(stat_illegal),
`endif
      .out_illegal(out_illegal));

   always #5 clk = ~clk;

   // Combinational ALU the issuer drives
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'b0000: alu_result = alu_a + alu_b;
         4'b0001: alu_result = alu_a - alu_b;
         4'b0010: alu_result = alu_a & alu_b;
         4'b0011: alu_result = alu_a | alu_b;
         4'b0100: alu_result = alu_a ^ alu_b;
         4'b0101: alu_result = alu_a << alu_b[5:0];
         4'b0110: alu_result = alu_a >> alu_b[5:0];
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   typedef struct packed {
      logic [DW-1:0] res;
      logic          zero;
      logic          ill;
   } exp_t;

   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                  input logic [DW-1:0] rs1, rs2, imm);
      exp_t e;
      logic [DW-1:0] b, r;
      logic ok;
      ok = 1'b1;
      r  = '0;
      b  = (op == I_OP) ? imm : rs2;
      if (op == R_OP || op == I_OP) begin
         case (f3)
            3'd0: r = (op == R_OP && f75) ? rs1 - b : rs1 + b;
            3'd7: r = rs1 & b;
            3'd6: r = rs1 | b;
            3'd4: r = rs1 ^ b;
            3'd1: if (f75) ok = 1'b0; else r = rs1 << (b % 64);
            3'd5: if (f75) ok = 1'b0; else r = rs1 >> (b % 64);
            default: ok = 1'b0;
         endcase
      end else if (op == LD_OP || op == ST_OP) r = rs1 + imm;
      else if (op == BR_OP && (f3 == 3'd0 || f3 == 3'd1)) r = rs1 - rs2;
      else ok = 1'b0;
      if (!ok) r = '0;
      e.res  = r;
      e.zero = (r == '0);
      e.ill  = !ok;
      return e;
   endfunction

   int   n_cmp = 0, n_bad = 0, cyc = 0;
   exp_t sbq[$];
   int   pop_cyc[$];
   logic rand_rdy = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus side of the scoreboard: push the expected response on every accept
   always @(negedge clk) begin
      if (reset) begin
         sbq.delete();
`ifdef ALU_OP_ISSUER_STATS_EN
         m_issued  = 0;
         m_illegal = 0;
`endif
      end else if (in_valid && in_ready) begin
         exp_t e;
         e = model(in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm);
         sbq.push_back(e);
`ifdef ALU_OP_ISSUER_STATS_EN
         m_issued++;
         if (e.ill) m_illegal++;
`endif
      end
   end

   // Monitor: pop and compare on each output handshake, and check stall stability
   logic          hold = 1'b0;
   logic [DW-1:0] h_res;
   logic          h_zero, h_ill;
   always @(negedge clk) begin
      if (reset) hold = 1'b0;
      else begin
         if (hold) begin
            check("stall_valid", DW'(out_valid), DW'(1));
            check("stall_result", out_result, h_res);
            check("stall_flags", DW'({out_zero, out_illegal}), DW'({h_zero, h_ill}));
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) check("unexpected_output", DW'(out_valid), DW'(0));
            else begin
               exp_t e;
               e = sbq.pop_front();
               check("out_result", out_result, e.res);
               check("out_zero", DW'(out_zero), DW'(e.zero));
               check("out_illegal", DW'(out_illegal), DW'(e.ill));
               pop_cyc.push_back(cyc);
            end
         end
         hold  = out_valid && !out_ready;
         h_res = out_result;
         h_zero = out_zero;
         h_ill  = out_illegal;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom % 4) != 0;
   endtask

   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic [DW-1:0] rs1, rs2, imm, output int waits);
      logic acc;
      in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7_5 = f75;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      waits = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         tick();
         waits++;
         if (waits > 1000) begin
            check("send_timeout", DW'(acc), DW'(1));
            acc = 1'b1;
         end
      end while (!acc);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((sbq.size() != 0 || out_valid) && n < 300) begin
         tick();
         n++;
      end
      tick();
      check("drain_empty", DW'(sbq.size()), DW'(0));
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      int w, p0;
      logic [2:0] rf3;
      logic [6:0] rop;
      logic [DW-1:0] r1, r2;
      logic [11:0] i12;
      reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0;
      in_rs1 = '0; in_rs2 = '0; in_imm = '0; out_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", DW'(in_ready), DW'(1));
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_alu_ctrl", DW'(alu_ctrl), DW'(0));
      check("rst_alu_a", alu_a, '0);
      check("rst_alu_b", alu_b, '0);
      check("rst_out_result", out_result, '0);
      check("rst_out_flags", DW'({out_zero, out_illegal}), DW'(0));
`ifdef ALU_OP_ISSUER_STATS_EN
      check("rst_stat_issued", DW'(stat_issued), DW'(0));
`endif
      tick();

      // SUB 10-5: ctrl one cycle after accept, result two cycles after
      out_ready = 1'b1;
      send(R_OP, 3'd0, 1'b1, 64'd10, 64'd5, 64'd0, w);
      @(negedge clk);
      check("sub_ctrl", DW'(alu_ctrl), DW'(1));
      check("sub_not_yet_valid", DW'(out_valid), DW'(0));
      tick();
      @(negedge clk);
      check("sub_valid", DW'(out_valid), DW'(1));
      check("sub_result", out_result, 64'd5);
      drain();

      // BEQ with equal operands
      send(BR_OP, 3'd0, 1'b0, 64'h1234, 64'h1234, 64'd0, w);
      @(negedge clk);
      check("beq_ctrl", DW'(alu_ctrl), DW'(1));
      tick();
      @(negedge clk);
      check("beq_zero", DW'({out_valid, out_zero, out_illegal}), DW'(3'b110));
      drain();

      // SRAI is unsupported
`ifdef ALU_OP_ISSUER_STATS_EN
      p0 = int'(stat_illegal);
`endif
      send(I_OP, 3'd5, 1'b1, 64'hFF, 64'd0, 64'd3, w);
      @(negedge clk);
      check("srai_issue", DW'({alu_ctrl, alu_a[7:0], alu_b[7:0]}), DW'(0));
      tick();
      @(negedge clk);
      check("srai_out", DW'({out_valid, out_zero, out_illegal}), DW'(3'b111));
      check("srai_result", out_result, '0);
`ifdef ALU_OP_ISSUER_STATS_EN
      check("srai_stat_illegal", DW'(stat_illegal), DW'(p0 + 1));
`endif
      drain();

      // Back-to-back stream at full throughput
      p0 = pop_cyc.size();
      send(I_OP, 3'd0, 1'b0, 64'd3, 64'd0, 64'd4, w);  check("stream_rdy0", DW'(w), DW'(1));
      send(R_OP, 3'd1, 1'b0, 64'd3, 64'd2, 64'd0, w);  check("stream_rdy1", DW'(w), DW'(1));
      send(R_OP, 3'd5, 1'b0, 64'd8, 64'd2, 64'd0, w);  check("stream_rdy2", DW'(w), DW'(1));
      send(R_OP, 3'd4, 1'b0, 64'd12, 64'd10, 64'd0, w); check("stream_rdy3", DW'(w), DW'(1));
      drain();
      check("stream_count", DW'(pop_cyc.size() - p0), DW'(4));
      if (pop_cyc.size() - p0 == 4) check("stream_consecutive", DW'(pop_cyc[p0 + 3] - pop_cyc[p0]), DW'(3));

      // Stall with two requests in flight
      out_ready = 1'b0;
      send(R_OP, 3'd0, 1'b0, 64'd1, 64'd2, 64'd0, w);
      send(R_OP, 3'd6, 1'b0, 64'hF0, 64'h0F, 64'd0, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", DW'(in_ready), DW'(0));
         tick();
      end
      drain();

      // Reset while stalled drops both in-flight requests
      out_ready = 1'b0;
      send(R_OP, 3'd7, 1'b0, 64'd6, 64'd3, 64'd0, w);
      send(LD_OP, 3'd3, 1'b0, 64'd100, 64'd0, 64'd8, w);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_out_valid", DW'(out_valid), DW'(0));
      check("rst_mid_in_ready", DW'(in_ready), DW'(1));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check("rst_mid_no_output", DW'(out_valid), DW'(0));
      end

      // Randomized traffic with random back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom % 4 == 0) tick();
         else begin
            case ($urandom % 8)
               0, 1, 2: rop = R_OP;
               3, 4:    rop = I_OP;
               5:       rop = ($urandom % 2) ? LD_OP : ST_OP;
               6:       rop = BR_OP;
               default: rop = 7'($urandom);
            endcase
            rf3 = 3'($urandom);
            r1  = rnd64();
            r2  = ($urandom % 5 == 0) ? r1 : rnd64();
            if ($urandom % 2) r2 = DW'($urandom % 80);
            i12 = 12'($urandom);
            send(rop, rf3, 1'($urandom), r1, r2, {{(DW-12){i12[11]}}, i12}, w);
         end
      end
      drain();
`ifdef ALU_OP_ISSUER_STATS_EN
      check("stat_issued", DW'(stat_issued), DW'(m_issued));
      check("stat_illegal", DW'(stat_illegal), DW'(m_illegal));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Initiator-side front end for the 64-bit combinational ALU. It accepts decoded instruction fields and operands over a valid/ready handshake, and generates the 4-bit ALU control code and operands.
- It drives the ALU from registers and captures Result/Zero into an output register that has its own valid/ready handshake.
- It sits between the decode stage and the ALU, replacing ad-hoc combinational ALU control.

Parameters:
- DATA_WIDTH, 64, operand/result width; shift amount uses the low log2(DATA_WIDTH) bits of B.
- STATS_WIDTH, 32, width of the statistics counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  issuer can accept a request
- in_opcode  input  7  RISC-V opcode field
- in_funct3  input  3  funct3 field
- in_funct7_5  input  1  bit 30 of the instruction
- in_rs1  input  DATA_WIDTH  rs1 operand value
- in_rs2  input  DATA_WIDTH  rs2 operand value
- in_imm  input  DATA_WIDTH  sign-extended immediate
- alu_a  output  DATA_WIDTH  ALU operand A (registered)
- alu_b  output  DATA_WIDTH  ALU operand B (registered)
- alu_ctrl  output  4  ALU control code (registered)
- alu_result  input  DATA_WIDTH  ALU Result (combinational return)
- alu_zero  input  1  ALU Zero flag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  DATA_WIDTH  captured result
- out_zero  output  1  captured zero flag
- out_illegal  output  1  request was not a supported operation

Behaviour:
- Control codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL.
- Decode, opcode 0110011 (R-type), B=rs1/rs2 operands:
  - f3=000: ADD if f7_5=0, SUB if f7_5=1.
  - f3=111: AND. f3=110: OR. f3=100: XOR.
  - f3=001 with f7_5=0: SLL. f3=101 with f7_5=0: SRL.
- Decode, opcode 0010011 (I-type), A=rs1, B=imm: same f3 mapping, no SUB. f3=000 is always ADD. Shifts require f7_5=0.
- Decode, opcode 0000011/0100011 (load/store address): ADD, A=rs1, B=imm.
- Decode, opcode 1100011 with f3 000/001 (BEQ/BNE): SUB, A=rs1, B=rs2.
- Illegal: anything else, including SRA/SRAI (f3=101, f7_5=1), SLT/SLTU and unsupported branches.
  - Stage 1 loads alu_a=0, alu_b=0, alu_ctrl=0000.
  - Output has result 0, zero 1, illegal 1.
- Two-stage pipeline, each stage with a valid bit:
  - S1 (issue register): holds alu_a, alu_b, alu_ctrl, illegal.
  - S2 (output register): holds out_result, out_zero, out_illegal.
- Latency: accept in cycle N (in_valid & in_ready) -> out_valid=1 in cycle N+2 at earliest.
- s2_adv = s1_valid & (!out_valid | out_ready). in_ready = !s1_valid | s2_adv (combinational, no in_valid dependency).
- On s2_adv, S2 captures alu_result/alu_zero from the current S1 contents.
- Simultaneous out handshake and S2 reload in one cycle is legal: full throughput, one result per cycle.
- Stall: out_valid & !out_ready holds S2 and S1 stable. Then in_ready=0 if S1 is valid.
- out_result, out_zero and out_illegal are stable while out_valid & !out_ready.
- out_valid is never withdrawn without a handshake.
- Input fields are sampled only on accept; values while in_valid=0 are don't-care.
- Reset: all valid bits 0, in_ready 1 (first cycle after reset). alu_a/alu_b 0, alu_ctrl 0000. out_valid 0, out_result 0, out_zero 0, out_illegal 0.
- Reset mid-operation discards both in-flight requests; no out_valid is asserted for them.
- Shift: SLL/SRL use B[5:0] only (ALU behaviour); the issuer does not mask B.

Optional Feature:
- Macro ALU_OP_ISSUER_STATS_EN.
- Defined: adds output ports stat_issued [STATS_WIDTH] (count of accepted requests) and stat_illegal [STATS_WIDTH] (count of accepted illegal requests).
  - Both counters reset to 0, increment on accept, and wrap modulo 2^STATS_WIDTH.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, alu_ctrl=0000, out_result=0.
- R-type SUB (f3=000, f7_5=1), rs1=10, rs2=5, out_ready=1 -> alu_ctrl=0001 one cycle after accept; out_result=5, out_zero=0 two cycles after accept.
- BEQ, rs1=rs2=0x1234 -> alu_ctrl=0001, out_result=0, out_zero=1, out_illegal=0.
- SRAI (0010011, f3=101, f7_5=1) -> out_illegal=1, out_result=0, out_zero=1; with stats, stat_illegal increments by 1.
- Back-to-back stream ADDI rs1=3 imm=4; SLL 3<<2; SRL 8>>2; XOR 12^10, out_ready=1 -> results 7, 12, 2, 6 on four consecutive cycles, in_ready held 1.
- Hold out_ready=0 for 3 cycles with 2 requests in flight -> in_ready=0 and out_result stable; release -> results delivered in order with no loss or duplication. Assert reset during the stall -> out_valid=0 next cycle.
